// File: rtl/fp_add_arbiter_if.sv
// Request, adder and response signals shared between fp_add_arbiter and its environment.
// slave is the arbiter side; master is the requester/adder side.
interface fp_add_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
);
    logic                    arb_en;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*32-1:0]   req_a;
    logic [NUM_REQ*32-1:0]   req_b;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    add_in_valid;
    logic [31:0]             add_a;
    logic [31:0]             add_b;
    logic [31:0]             add_result;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [31:0]             rsp_data;
    logic                    busy;

    modport slave (
        input  arb_en, req_valid, req_a, req_b, add_result,
        output req_ready, add_in_valid, add_a, add_b, rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output arb_en, req_valid, req_a, req_b, add_result,
        input  req_ready, add_in_valid, add_a, add_b, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP32 adder; results are steered back by ID.
// Define FP_ADD_ARB_PRIO0_EN to give requester 0 fixed top priority over the rotating rest.
module fp_add_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADD_LATENCY = 3,
    parameter int unsigned ID_W        = 2
) (
    input logic             clk,
    input logic             rst,
    fp_add_arbiter_if.slave bus
);
`ifdef FP_ADD_ARB_PRIO0_EN
    localparam bit Prio0 = 1'b1;
`else
    localparam bit Prio0 = 1'b0;
`endif

    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      grant_id;
    logic [ID_W-1:0]      idx;
    logic                 found;
    logic                 rotate;
    logic [ID_W-1:0]      last_grant_q, last_grant_d;
    logic                 vld_q, vld_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [31:0]          a_q, a_d;
    logic [31:0]          b_q, b_d;
    logic [ADD_LATENCY-1:0] trk_vld_q;
    logic [ID_W-1:0]      trk_id_q [ADD_LATENCY];

    always_comb begin
        grant    = '0;
        grant_id = last_grant_q;
        idx      = '0;
        found    = 1'b0;
        rotate   = 1'b0;
        if (!rst && bus.arb_en) begin
            if (Prio0 && bus.req_valid[0]) begin
                grant[0] = 1'b1;
                grant_id = '0;
                found    = 1'b1;
            end
            for (int unsigned off = 1; off <= NUM_REQ; off++) begin
                idx = ID_W'((32'(last_grant_q) + off) % NUM_REQ);
                if (!found && bus.req_valid[idx] && !(Prio0 && idx == '0)) begin
                    grant[idx] = 1'b1;
                    grant_id   = idx;
                    found      = 1'b1;
                    rotate     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        last_grant_d = rotate ? grant_id : last_grant_q;
        vld_d        = found;
        id_d         = found ? grant_id : id_q;
        a_d          = found ? bus.req_a[{grant_id, 5'd0} +: 32] : a_q;
        b_d          = found ? bus.req_b[{grant_id, 5'd0} +: 32] : b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            vld_q        <= 1'b0;
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            trk_vld_q    <= '0;
            for (int i = 0; i < int'(ADD_LATENCY); i++) trk_id_q[i] <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            vld_q        <= vld_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            // Entry 0 follows the issue register, so the last entry lines up with add_result.
            trk_vld_q[0] <= vld_q;
            trk_id_q[0]  <= id_q;
            for (int i = 1; i < int'(ADD_LATENCY); i++) begin
                trk_vld_q[i] <= trk_vld_q[i-1];
                trk_id_q[i]  <= trk_id_q[i-1];
            end
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_id    = '0;
        if (trk_vld_q[ADD_LATENCY-1]) begin
            bus.rsp_valid[trk_id_q[ADD_LATENCY-1]] = 1'b1;
            bus.rsp_id                             = trk_id_q[ADD_LATENCY-1];
        end
    end

    assign bus.req_ready    = grant;
    assign bus.add_in_valid = vld_q;
    assign bus.add_a        = a_q;
    assign bus.add_b        = b_q;
    assign bus.rsp_data     = bus.add_result;
    assign bus.busy         = vld_q | (|trk_vld_q);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
        a_operand_hold : assert property (@(posedge clk) disable iff (rst)
            (bus.req_valid[i] && !bus.req_ready[i]) |=>
            (!bus.req_valid[i] || ($stable(bus.req_a[32*i +: 32]) &&
                                   $stable(bus.req_b[32*i +: 32]))));
    end
endmodule
